// File: rtl/wb_pipe_stage_pkg.sv
// Shared types for the write-back pipeline stage: payload widths, the
// {result, rd, regwrite} bundle and the x0 write-squash helper.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } wb_bundle_t;

  // Writes to x0 are architecturally discarded, so drop the enable at capture.
  function automatic wb_bundle_t squash_x0(input wb_bundle_t b);
    wb_bundle_t r;
    r = b;
    if (b.rd == '0) r.regwrite = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/wb_pipe_stage_if.sv
// MEM-to-WB handshake bundle: upstream valid/ready with payload, downstream
// valid/ready with the head entry, plus the stage occupancy.
interface wb_pipe_stage_if #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int REG_AW = pipe_pkg::REG_AW
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_result;
  logic [REG_AW-1:0] in_rd;
  logic              in_regwrite;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic [REG_AW-1:0] out_rd;
  logic              out_regwrite;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_result, in_rd, in_regwrite, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_regwrite, occupancy
  );

  modport slave (
    input  in_valid, in_result, in_rd, in_regwrite, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_regwrite, occupancy
  );
endinterface

// File: rtl/wb_pipe_stage_skid_slot.sv
// One storage entry of the write-back stage: loads a bundle, clears back to
// an all-zero empty entry, and reports whether it holds a bundle.
module wb_skid_slot
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  wb_bundle_t d,
  output logic       valid,
  output wb_bundle_t q
);

  // Empty entries hold zero payload so downstream never sees stale data.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage register with valid/ready handshake, flush and
// x0 squash. Define WB_PIPE_SKID_EN for a 2-entry stage with registered in_ready.
module wb_pipe_stage #(
  parameter int XLEN            = pipe_pkg::XLEN,
  parameter int REG_AW          = pipe_pkg::REG_AW,
  parameter int ZERO_REG_SQUASH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  wb_pipe_stage_if.slave   bus
);
  import pipe_pkg::*;

  logic [XLEN-1:0]   in_res;
  logic [REG_AW-1:0] in_dst;
  wb_bundle_t        incoming;
  wb_bundle_t        captured;
  wb_bundle_t        head_d;
  wb_bundle_t        head_q;
  logic              head_valid;
  logic              head_load;
  logic              head_clear;
  logic              accept;
  logic              pop;

  assign in_res   = bus.in_result;
  assign in_dst   = bus.in_rd;
  assign incoming = '{result: in_res, rd: in_dst, regwrite: bus.in_regwrite};
  assign captured = (ZERO_REG_SQUASH != 0) ? squash_x0(incoming) : incoming;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = head_valid && bus.out_ready;

`ifdef WB_PIPE_SKID_EN
  wb_bundle_t skid_q;
  logic       skid_valid;
  logic       skid_load;
  logic       skid_clear;

  // Skid can only be occupied while head is, so !skid_valid means occupancy < 2.
  assign bus.in_ready = !skid_valid;

  assign head_d     = skid_valid ? skid_q : captured;
  assign head_load  = !flush && ((pop && skid_valid) || (accept && (!head_valid || pop)));
  assign head_clear = flush || (pop && !head_load);
  assign skid_load  = !flush && accept && head_valid && !pop;
  assign skid_clear = flush || (pop && skid_valid);

  wb_skid_slot u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (skid_clear),
    .load  (skid_load),
    .d     (captured),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign bus.occupancy = {1'b0, head_valid} + {1'b0, skid_valid};
`else
  // Single entry: a pop frees the slot in the same cycle, so accept may overlap it.
  assign bus.in_ready = !head_valid || bus.out_ready;

  assign head_d     = captured;
  assign head_load  = !flush && accept;
  assign head_clear = flush || (pop && !accept);

  assign bus.occupancy = {1'b0, head_valid};
`endif

  wb_skid_slot u_head (
    .clk   (clk),
    .reset (reset),
    .clear (head_clear),
    .load  (head_load),
    .d     (head_d),
    .valid (head_valid),
    .q     (head_q)
  );

  assign bus.out_valid    = head_valid;
  assign bus.out_result   = head_q.result;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_regwrite = head_q.regwrite && head_valid;

endmodule
